btb_ctrl: RTL
=============

BTB_CTRL -- requirements
Module: btb_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 4: number of BTB array entries (power of 2).
REQ-002 SHALL have parameter IDXW, default 2: index width, equal to log2(ENTRIES).
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk input 1, rising-edge clock.
REQ-004 SHALL have rst input 1: synchronous active-high reset.
REQ-005 SHALL have lk_valid input 1: fetch lookup request.
REQ-006 SHALL have lk_pc input 32: fetch PC.
REQ-007 SHALL have lk_ready output 1: lookup accepted this cycle when high with lk_valid.
REQ-008 SHALL have rsp_valid, rsp_hit output 1 each: lookup response and hit flag.
REQ-009 SHALL have rsp_target output 32: predicted next PC.
REQ-010 SHALL have upd_valid input 1, upd_pc input 32, upd_target input 32, upd_taken input 1: resolved-branch update from execute.
REQ-011 SHALL have upd_ready output 1: update enqueued when high with upd_valid.
REQ-012 SHALL have flush_req input 1 and flush_done output 1: invalidate-all request and completion pulse.
REQ-013 SHALL have array port arr_en, arr_we output 1 each, arr_idx output IDXW, arr_wvalid output 1, arr_wtag output 30-IDXW, arr_wtgt output 32.
REQ-014 SHALL have array read data arr_rvalid input 1, arr_rtag input 30-IDXW, arr_rtgt input 32; read data is valid the cycle after arr_en=1, arr_we=0.

Function
REQ-015 SHALL split addresses as idx = pc[IDXW+1:2] and tag = pc[31:IDXW+2].
REQ-016 SHALL issue at most one array access per cycle (single-port array).
REQ-017 SHALL implement FSM states FLUSH and RUN.
- FLUSH: writes idx 0..ENTRIES-1 with arr_wvalid=0, one per cycle, ascending; moves to RUN after idx ENTRIES-1 is written.
REQ-018 SHALL pulse flush_done for exactly one cycle, the cycle after the last FLUSH write.
REQ-019 SHALL hold a 2-deep update FIFO of {pc, target, taken}.
- upd_ready = state==RUN && FIFO not full && !flush_req.
REQ-020 SHALL arbitrate in RUN with fixed priority:
- (1) FIFO full -> drain head;
- (2) lk_valid -> lookup;
- (3) FIFO non-empty -> drain head;
- (4) idle, arr_en=0.
REQ-021 SHALL drive lk_ready = state==RUN && !flush_req && FIFO not full.
REQ-022 SHALL write each drained update as arr_we=1, arr_idx=idx(pc), arr_wtag=tag(pc), arr_wtgt=target, arr_wvalid=taken; taken=0 invalidates the entry.
REQ-023 SHALL assert rsp_valid exactly one cycle after an accepted lookup.
- rsp_hit = arr_rvalid && arr_rtag==registered tag.
- rsp_target = arr_rtgt on hit, else registered lk_pc+4 (mod 2^32).
REQ-024 SHALL sustain one lookup per cycle back-to-back while the FIFO is not full.
REQ-025 SHALL provide no bypass from FIFO contents to lookups; a lookup before the drain write returns the old array content.
REQ-026 SHALL accept an update in the same cycle the FIFO drains when not full; simultaneous enqueue and dequeue keeps occupancy unchanged.
REQ-027 SHALL, on flush_req in any state, clear the FIFO, (re)enter FLUSH with write index 0, and discard any update or lookup presented that cycle.
- A pending rsp_valid from the prior cycle still completes.
REQ-028 SHALL, on flush_req during FLUSH, restart the sweep at idx 0; flush_done pulses only after a complete uninterrupted sweep.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, set the FIFO empty, write index 0, and state FLUSH.
- Outputs: rsp_valid=0, rsp_hit=0, rsp_target=0, flush_done=0, arr_en=0, arr_we=0.
REQ-030 SHALL sweep the array after rst deasserts, as in REQ-017.
- lk_ready=0 and upd_ready=0 for ENTRIES cycles; flush_done pulses in cycle ENTRIES+1.
REQ-031 SHALL abandon any sweep, FIFO contents and in-flight response on reset mid-operation; the sweep restarts from idx 0.

Verification
REQ-032 SHALL cover reset release, ENTRIES=4: arr_we=1, arr_wvalid=0 at idx 0,1,2,3 in cycles 1-4, flush_done=1 in cycle 5, lk_ready=1 from cycle 5.
REQ-033 SHALL cover update pc=0x100, target=0x200, taken=1, then lookup 0x100 after drain: rsp_hit=1, rsp_target=0x200; lookup 0x110 (same idx, other tag): rsp_hit=0, rsp_target=0x114.
REQ-034 SHALL cover two updates with lk_valid held high: FIFO fills, lk_ready=0 one cycle, head drains first, then lookups resume one per cycle.
REQ-035 SHALL cover flush_req with 2 queued updates: FIFO emptied, 4 invalidate writes, flush_done, lookup of the previously written pc returns rsp_hit=0.
REQ-036 SHALL cover update pc=0x100 taken=0 after a taken entry: entry invalidated, lookup 0x100 gives rsp_hit=0, rsp_target=0x104.
REQ-037 SHALL cover rst asserted during sweep at idx 2: sweep restarts at idx 0, flush_done only after idx 3.

Source files
------------

// File: rtl/btb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : btb_ctrl
// Description : Controller for a direct-mapped Branch Target Buffer that sits
//               in front of a single-port array (one access per cycle).
//               - After reset or on flush_req, it sweeps the array and
//                 invalidates every entry, then pulses flush_done.
//               - It serves fetch lookups. The response arrives one cycle
//                 after acceptance: the predicted target on a hit, otherwise
//                 pc+4.
//               - It queues resolved-branch updates in a 2-deep FIFO and
//                 drains them into the array when the port is free. A full
//                 FIFO takes the port ahead of lookups.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               lk_valid/lk_pc/lk_ready  - fetch lookup request handshake
//               rsp_valid/hit/target     - lookup response (one cycle later)
//               upd_valid/pc/target/taken, upd_ready - update enqueue
//               flush_req/flush_done     - invalidate-all request / done pulse
//               arr_*                    - single-port BTB array interface
// Revision    : 1.0 - initial release
// ============================================================================
module btb_ctrl #(
    parameter int ENTRIES = 4,
    parameter int IDXW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    // fetch lookup
    input  logic               lk_valid,
    input  logic [31:0]        lk_pc,
    output logic               lk_ready,
    output logic               rsp_valid,
    output logic               rsp_hit,
    output logic [31:0]        rsp_target,
    // resolved-branch update
    input  logic               upd_valid,
    input  logic [31:0]        upd_pc,
    input  logic [31:0]        upd_target,
    input  logic               upd_taken,
    output logic               upd_ready,
    // invalidate-all
    input  logic               flush_req,
    output logic               flush_done,
    // array port
    output logic               arr_en,
    output logic               arr_we,
    output logic [IDXW-1:0]    arr_idx,
    output logic               arr_wvalid,
    output logic [29-IDXW:0]   arr_wtag,
    output logic [31:0]        arr_wtgt,
    input  logic               arr_rvalid,
    input  logic [29-IDXW:0]   arr_rtag,
    input  logic [31:0]        arr_rtgt
);

    localparam int              TAGW     = 30 - IDXW;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ENTRIES - 1);

    typedef enum logic [0:0] {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [IDXW-1:0]   widx_q;
    logic              flush_done_q;

    // Update FIFO: two slots addressed by a read pointer plus an occupancy count.
    logic [31:0]       fifo_pc_q  [2];
    logic [31:0]       fifo_tgt_q [2];
    logic              fifo_tkn_q [2];
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;

    // Lookup response context, captured at acceptance
    logic              rsp_valid_q;
    logic [TAGW-1:0]   rsp_tag_q;
    logic [31:0]       rsp_pc_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic              fifo_full;
    logic              fifo_empty;
    logic              run_ok;
    logic              do_sweep;
    logic              do_drain;
    logic              do_lookup;
    logic              do_enq;
    logic              wr_ptr;
    logic [31:0]       head_pc;
    logic [31:0]       head_tgt;
    logic              head_tkn;
    logic              unused_head_lsbs;

    assign fifo_full  = (count_q == 2'd2);
    assign fifo_empty = (count_q == 2'd0);

    // rst is folded in so that no array access or handshake is seen while
    // the block is held in reset.
    assign run_ok   = !rst && (state_q == ST_RUN) && !flush_req;
    assign do_sweep = !rst && (state_q == ST_FLUSH) && !flush_req;

    assign lk_ready  = run_ok && !fifo_full;
    assign upd_ready = run_ok && !fifo_full;

    // A full FIFO takes the port first so lookups cannot starve updates.
    // Otherwise lookups win and the FIFO drains in idle cycles.
    assign do_lookup = lk_ready && lk_valid;
    assign do_drain  = run_ok && (fifo_full || (!lk_valid && !fifo_empty));
    assign do_enq    = upd_ready && upd_valid;

    assign head_pc  = fifo_pc_q[rd_ptr_q];
    assign head_tgt = fifo_tgt_q[rd_ptr_q];
    assign head_tkn = fifo_tkn_q[rd_ptr_q];

    // PC bits [1:0] carry no index or tag information.
    assign unused_head_lsbs = ^head_pc[1:0];

    // The free slot is the one after the head when a single entry is queued.
    // On an enqueue with a simultaneous dequeue at count 1, this slot becomes
    // the new head.
    assign wr_ptr = rd_ptr_q ^ (count_q == 2'd1);

    always_comb begin
        count_d = count_q;
        case ({do_enq, do_drain})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Array port mux (at most one access per cycle)
    // ------------------------------------------------------------------
    always_comb begin
        arr_en     = 1'b0;
        arr_we     = 1'b0;
        arr_idx    = '0;
        arr_wvalid = 1'b0;
        arr_wtag   = '0;
        arr_wtgt   = '0;
        if (do_sweep) begin
            arr_en  = 1'b1;
            arr_we  = 1'b1;
            arr_idx = widx_q;
        end else if (do_drain) begin
            arr_en     = 1'b1;
            arr_we     = 1'b1;
            arr_idx    = head_pc[IDXW+1:2];
            arr_wtag   = head_pc[31:IDXW+2];
            arr_wtgt   = head_tgt;
            // A not-taken resolution clears the entry rather than training it.
            arr_wvalid = head_tkn;
        end else if (do_lookup) begin
            arr_en  = 1'b1;
            arr_idx = lk_pc[IDXW+1:2];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: invalidate sweep / run
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FLUSH;
            widx_q       <= '0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            if (flush_req) begin
                // Any request (including one arriving mid-sweep) restarts from
                // index 0, so flush_done only follows a complete sweep.
                state_q <= ST_FLUSH;
                widx_q  <= '0;
            end else if (state_q == ST_FLUSH) begin
                if (widx_q == LAST_IDX) begin
                    state_q      <= ST_RUN;
                    widx_q       <= '0;
                    flush_done_q <= 1'b1;
                end else begin
                    widx_q <= widx_q + IDXW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Update FIFO and response tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_pc_q    <= '0;
        end else begin
            // A response already in flight completes even across a flush,
            // because do_lookup is only suppressed for the new request.
            rsp_valid_q <= do_lookup;
            if (do_lookup) begin
                rsp_tag_q <= lk_pc[31:IDXW+2];
                rsp_pc_q  <= lk_pc;
            end
            if (flush_req) begin
                rd_ptr_q <= 1'b0;
                count_q  <= 2'd0;
            end else begin
                if (do_drain) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                count_q <= count_d;
            end
        end
    end

    // Payload storage needs no reset: the occupancy count qualifies it.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            fifo_pc_q[wr_ptr]  <= upd_pc;
            fifo_tgt_q[wr_ptr] <= upd_target;
            fifo_tkn_q[wr_ptr] <= upd_taken;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_valid_q && arr_rvalid && (arr_rtag == rsp_tag_q);
    assign rsp_target = !rsp_valid_q ? '0 :
                        rsp_hit      ? arr_rtgt : (rsp_pc_q + 32'd4);
    assign flush_done = flush_done_q;

endmodule
`default_nettype wire
